// File: rtl/psram_cfg_pkg.sv
// Shared constants for the PSRAM configuration scheduler:
// cfg field positions, register index codes, FSM states.
package psram_cfg_pkg;

  localparam int DLEN_LSB = 17;
  localparam int DLEN_W   = 15;
  localparam int SDIV_LSB = 13;
  localparam int SDIV_W   = 4;
  localparam int SIO_BIT  = 12;
  localparam int DDIR_BIT = 11;
  localparam int DWID_LSB = 9;
  localparam int WAIT_LSB = 5;
  localparam int AWID_LSB = 3;
  localparam int CMDO_BIT = 2;
  localparam int CWID_LSB = 0;
  localparam int ADDR_LSB = 8;
  localparam int CMD_LSB  = 0;

  typedef enum logic [1:0] {
    IDX_CFG0  = 2'd0,
    IDX_CFG1  = 2'd1,
    IDX_CFG2  = 2'd2,
    IDX_START = 2'd3
  } wr_idx_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARB   = 2'd1,
    S_ISSUE = 2'd2,
    S_BUSY  = 2'd3
  } state_e;

  function automatic int len_w(input int ram_width);
    return 32 - ram_width;
  endfunction

endpackage

// File: rtl/psram_rr_arb.sv
// Round-robin arbiter: first request at or after ptr wins.
// Ports: req/ptr in; one-hot gnt, gnt index and any-request out.
module psram_rr_arb #(
  parameter int NUM_CH = 2,
  parameter int CH_W   = 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   idx,
  output logic              any
);

  int c;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      c = (int'(ptr) + k) % NUM_CH;
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = CH_W'(c);
      end
    end
  end

endmodule

// File: rtl/psram_cfg_sched.sv
// PSRAM transfer-config scheduler: per-channel cfg regs, start
// validation, round-robin issue to the engine, done tracking.
module psram_cfg_sched
  import psram_cfg_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int RAM_WIDTH = 17,
  parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LEN_W    = len_w(RAM_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [CH_W-1:0]      wr_ch,
  input  logic [1:0]           wr_idx,
  input  logic [31:0]          wr_data,
  output logic                 wr_err,
  output logic                 cfg_vld,
  input  logic                 cfg_rdy,
  input  logic                 xfer_done,
  output logic [CH_W-1:0]      act_ch,
  output logic [14:0]          data_len,
  output logic [3:0]           sck_div,
  output logic                 single_line_io_mode,
  output logic                 data_dir,
  output logic [1:0]           data_width,
  output logic [3:0]           wait_cyc,
  output logic [1:0]           addr_width,
  output logic                 cmd_only,
  output logic [1:0]           cmd_width,
  output logic [23:0]          addr,
  output logic [7:0]           cmd,
  output logic [LEN_W-1:0]     dma_len,
  output logic [RAM_WIDTH-1:0] dma_saddr,
  output logic [NUM_CH-1:0]    pend,
  output logic [NUM_CH-1:0]    done_pls,
  output logic [NUM_CH-1:0]    cfg_err
);

  logic [31:0] cfg0_q [NUM_CH];
  logic [31:0] cfg1_q [NUM_CH];
  logic [31:0] cfg2_q [NUM_CH];
  logic [31:0] sh0_q, sh1_q, sh2_q;
  logic [31:0] nx0, nx1, nx2;

  state_e state_q, state_d;

  logic [CH_W-1:0]   rr_q, act_q, rr_nxt;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] err_q, err_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic              wr_err_q, wr_err_d;

  logic ch_ok, ch_busy, start_ok, cfg_wr;
  logic [DLEN_W-1:0] st_dl;
  logic [LEN_W-1:0]  st_ml;

  logic [NUM_CH-1:0] gnt;
  logic [CH_W-1:0]   gnt_idx;
  logic              gnt_any;

  psram_rr_arb #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req (pend_q),
    .ptr (rr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  // A channel stays pending until its done, so pending covers active.
  assign ch_ok   = int'(wr_ch) < NUM_CH;
  assign ch_busy = ch_ok && pend_q[wr_ch];
  assign cfg_wr  = wr_en && ch_ok && !ch_busy
                && (wr_idx != IDX_START);

  assign st_dl = cfg0_q[wr_ch][DLEN_LSB +: DLEN_W];
  assign st_ml = cfg2_q[wr_ch][31:RAM_WIDTH];

  // dma_len and data_len share RAM-word units.
  assign start_ok =
      (cfg0_q[wr_ch][SDIV_LSB +: SDIV_W] != '0)
   && (cfg0_q[wr_ch][CMDO_BIT]
       || ((st_dl != '0) && (32'(st_ml) >= 32'(st_dl))));

  assign rr_nxt = (int'(act_q) == NUM_CH - 1)
                ? '0 : act_q + 1'b1;

  always_comb begin
    nx0 = '0;
    nx1 = '0;
    nx2 = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) begin
        nx0 = nx0 | cfg0_q[i];
        nx1 = nx1 | cfg1_q[i];
        nx2 = nx2 | cfg2_q[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    err_d    = err_q;
    done_d   = '0;
    wr_err_d = 1'b0;
    cfg_vld  = 1'b0;
    if (wr_en) begin
      if (!ch_ok) begin
        wr_err_d = 1'b1;
      end else if (wr_idx != IDX_START) begin
        if (ch_busy) wr_err_d = 1'b1;
      end else if (wr_data[0]) begin
        if (ch_busy) begin
          wr_err_d = 1'b1;
        end else if (start_ok) begin
          pend_d[wr_ch] = 1'b1;
          err_d[wr_ch]  = 1'b0;
        end else begin
          err_d[wr_ch] = 1'b1;
        end
      end
    end
    unique case (state_q)
      S_IDLE: if (|pend_q) state_d = S_ARB;
      S_ARB: state_d = S_ISSUE;
      S_ISSUE: begin
        cfg_vld = 1'b1;
        if (cfg_rdy) state_d = S_BUSY;
      end
      S_BUSY: begin
        if (xfer_done) begin
          state_d       = S_IDLE;
          pend_d[act_q] = 1'b0;
          done_d[act_q] = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pend_q   <= '0;
      err_q    <= '0;
      done_q   <= '0;
      wr_err_q <= 1'b0;
      rr_q     <= '0;
      act_q    <= '0;
      sh0_q    <= '0;
      sh1_q    <= '0;
      sh2_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cfg0_q[i] <= '0;
        cfg1_q[i] <= '0;
        cfg2_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
      done_q   <= done_d;
      wr_err_q <= wr_err_d;
      if (cfg_wr) begin
        unique case (wr_idx)
          IDX_CFG0: cfg0_q[wr_ch] <= wr_data;
          IDX_CFG1: cfg1_q[wr_ch] <= wr_data;
          default:  cfg2_q[wr_ch] <= wr_data;
        endcase
      end
      if (state_q == S_ARB && gnt_any) begin
        sh0_q <= nx0;
        sh1_q <= nx1;
        sh2_q <= nx2;
        act_q <= gnt_idx;
      end
      if (state_q == S_BUSY && xfer_done) begin
        rr_q <= rr_nxt;
      end
    end
  end

  assign wr_err   = wr_err_q;
  assign pend     = pend_q;
  assign done_pls = done_q;
  assign cfg_err  = err_q;
  assign act_ch   = act_q;

  assign data_len            = sh0_q[DLEN_LSB +: DLEN_W];
  assign sck_div             = sh0_q[SDIV_LSB +: SDIV_W];
  assign single_line_io_mode = sh0_q[SIO_BIT];
  assign data_dir            = sh0_q[DDIR_BIT];
  assign data_width          = sh0_q[DWID_LSB +: 2];
  assign wait_cyc            = sh0_q[WAIT_LSB +: 4];
  assign addr_width          = sh0_q[AWID_LSB +: 2];
  assign cmd_only            = sh0_q[CMDO_BIT];
  assign cmd_width           = sh0_q[CWID_LSB +: 2];
  assign addr                = sh1_q[ADDR_LSB +: 24];
  assign cmd                 = sh1_q[CMD_LSB +: 8];
  assign dma_len             = sh2_q[31:RAM_WIDTH];
  assign dma_saddr           = sh2_q[RAM_WIDTH-1:0];

endmodule

// File: doc/psram_cfg_sched.md
Name: psram_cfg_sched

Overview:
Multi-channel PSRAM transfer-configuration scheduler. Software writes per-channel cfg0/cfg1/cfg2 words and a start request through a simple register write port. The block validates each request and arbitrates round-robin among pending channels. It latches the winner's words into an active shadow, presents the decoded fields to the PSRAM controller engine with a valid/ready handshake, and tracks completion per channel.

Parameters:
NUM_CH, 2, number of configuration channels (1..8)
RAM_WIDTH, 17, DMA start-address width; dma_len width is LEN_W = 32-RAM_WIDTH
CH_W, $clog2(NUM_CH) min 1, channel index width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  register write strobe
wr_ch  in  CH_W  target channel
wr_idx  in  2  0=cfg0, 1=cfg1, 2=cfg2, 3=start (wr_data[0]=1 requests)
wr_data  in  32  write data
wr_err  out  1  one-cycle pulse: write rejected
cfg_vld  out  1  active configuration valid to engine
cfg_rdy  in  1  engine accepts configuration
xfer_done  in  1  engine completion pulse for accepted transfer
act_ch  out  CH_W  channel of active configuration
data_len  out  15  cfg0[31:17]
sck_div  out  4  cfg0[16:13]
single_line_io_mode  out  1  cfg0[12]
data_dir  out  1  cfg0[11]
data_width  out  2  cfg0[10:9]
wait_cyc  out  4  cfg0[8:5]
addr_width  out  2  cfg0[4:3]
cmd_only  out  1  cfg0[2]
cmd_width  out  2  cfg0[1:0]
addr  out  24  cfg1[31:8]
cmd  out  8  cfg1[7:0]
dma_len  out  LEN_W  cfg2[31:RAM_WIDTH]
dma_saddr  out  RAM_WIDTH  cfg2[RAM_WIDTH-1:0]
pend  out  NUM_CH  per-channel pending flags
done_pls  out  NUM_CH  one-cycle completion pulse per channel
cfg_err  out  NUM_CH  sticky invalid-request flag, cleared by a new accepted start

Behaviour:
- Reset: all cfg words 0, active shadow 0, pend/done_pls/cfg_err/wr_err 0, cfg_vld 0, act_ch 0, rr pointer 0, state IDLE.
- Decoded outputs are pure slices of the active shadow. They are stable while cfg_vld=1 or state=BUSY.
- Writes: a write to idx 0..2 of a channel that is pending or active is dropped, and wr_err pulses the next cycle. wr_ch>=NUM_CH is dropped with wr_err.
- Start with wr_data[0]=1 is validated against the channel's stored words:
  - invalid if sck_div==0;
  - invalid if cmd_only==0 and data_len==0;
  - invalid if cmd_only==0 and dma_len<data_len (in RAM words, same units).
- Invalid start: set cfg_err[ch], pend stays 0.
- Valid start: set pend[ch] and clear cfg_err[ch].
- Start on a channel already pending or active: dropped, wr_err.
- FSM:
  - IDLE: if any pend, go to ARB.
  - ARB: pick the first pending channel at or after rr pointer (wrap modulo NUM_CH), copy its words to the shadow, set act_ch, go to ISSUE. 1-cycle latency.
  - ISSUE: cfg_vld=1. On cfg_rdy=1, go to BUSY with cfg_vld=0 next cycle.
  - BUSY: on xfer_done, clear pend[act_ch], pulse done_pls[act_ch], rr pointer = act_ch+1 mod NUM_CH, go to IDLE.
- Pending-to-cfg_vld latency: 2 cycles (IDLE->ARB->ISSUE). Back-to-back: done -> next cfg_vld after 3 cycles.
- xfer_done outside BUSY is ignored.
- A write/start to another channel in the same cycle as xfer_done is handled normally. A start for act_ch in the done cycle is still rejected (pend clears next edge).
- NUM_CH=1 degenerates to a single channel; rr pointer fixed at 0.
- rst_n asserted mid-transfer clears everything immediately; no done pulse.

Decomposition:
- Shared package psram_cfg_pkg:
  - cfg field bit-position constants and widths;
  - wr_idx encodings;
  - FSM state encoding (IDLE, ARB, ISSUE, BUSY);
  - LEN_W function of RAM_WIDTH.
- Sub-module psram_rr_arb (NUM_CH): request vector + pointer -> one-hot grant and index. Combinational, reusable by the DMA path.

Test Plan:
- Write ch0 cfg0=0x0002_2A4B, cfg1=0x1234_5603, cfg2 with dma_len=4, saddr=0x10, then start -> cfg_vld 2 cycles later; data_len=1, sck_div=1, addr=0x123456, cmd=0x03, dma_saddr=0x10, act_ch=0.
- Start ch1 with sck_div=0 -> cfg_err[1]=1, pend[1]=0, no cfg_vld. Rewrite cfg0 with sck_div=2, start again -> cfg_err[1]=0, pend[1]=1.
- Both channels pending, rr=0 -> ch0 served first. After xfer_done, done_pls[0] pulses and ch1 cfg_vld follows 3 cycles after done.
- cfg_rdy held low 10 cycles -> cfg_vld and all fields stable. Write to active channel's cfg1 -> wr_err pulse, addr unchanged.
- xfer_done pulsed in ISSUE -> ignored, state stays ISSUE.
- rst_n low during BUSY -> pend=0, cfg_vld=0, no done_pls. After release, fields read 0.
